first_circuit: RTL and testbench

//   Registered 3-term AND-OR-INVERT gate: y = ~((a&b) | (c&d) | (e&f)).
//   It also reports the per-term status, pulses on every output change and

---
 rtl/first_circuit_pkg.sv | 17 +
 rtl/first_circuit_aoi3.sv | 39 +++
 rtl/first_circuit.sv | 96 +++++++++
 tb/tb_first_circuit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/first_circuit_pkg.sv
// Shared constants for the first_circuit AOI glue block.
package first_circuit_pkg;

    // Bit positions of the product terms inside the terms vector
    localparam int TERM_AB = 0;
    localparam int TERM_CD = 1;
    localparam int TERM_EF = 2;

    localparam int NUM_TERMS = 3;

    // Output value after reset; equals the AOI result of all-zero inputs
    localparam logic Y_RST = 1'b1;

    // Default width of the saturating change counter
    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/first_circuit_aoi3.sv
// Purely combinational 3-term AND-OR-INVERT core: y_nxt = ~((a&b)|(c&d)|(e&f)).
module first_circuit_aoi3
    import first_circuit_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    input  logic                 d,
    input  logic                 e,
    input  logic                 f,
    output logic [NUM_TERMS-1:0] terms,
    output logic                 y_nxt
);

    logic [NUM_TERMS-1:0] left_in;
    logic [NUM_TERMS-1:0] right_in;

    // Group the operand pairs so that bit i of each vector forms product term i
    always_comb begin
        left_in           = '0;
        right_in          = '0;
        left_in[TERM_AB]  = a;
        right_in[TERM_AB] = b;
        left_in[TERM_CD]  = c;
        right_in[TERM_CD] = d;
        left_in[TERM_EF]  = e;
        right_in[TERM_EF] = f;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TERMS; gi++) begin : g_term
            assign terms[gi] = left_in[gi] & right_in[gi];
        end
    endgenerate

    assign y_nxt = ~(|terms);

endmodule

// File: rtl/first_circuit.sv
// Registered AOI gate with per-term status, change pulse and saturating
// change counter.
// Optional feature macro: FIRST_CIRCUIT_INREG_EN adds one input register
// stage in front of the AOI core (latency 2 instead of 1).
module first_circuit
    import first_circuit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    input  logic                 d,
    input  logic                 e,
    input  logic                 f,
    output logic                 y,
    output logic [NUM_TERMS-1:0] terms,
    output logic                 y_chg,
    output logic [CNT_W-1:0]     chg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Inputs as seen by the AOI core, packed {f,e,d,c,b,a}
    logic [5:0] in_s;

`ifdef FIRST_CIRCUIT_INREG_EN
    logic [5:0] in_reg;

    // Extra input stage; clears to zero so y stays at its reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            in_reg <= '0;
        end else begin
            in_reg <= {f, e, d, c, b, a};
        end
    end

    assign in_s = in_reg;
`else
    assign in_s = {f, e, d, c, b, a};
`endif

    logic [NUM_TERMS-1:0] terms_next;
    logic                 y_next;

    first_circuit_aoi3 u_aoi3 (
        .a     (in_s[0]),
        .b     (in_s[1]),
        .c     (in_s[2]),
        .d     (in_s[3]),
        .e     (in_s[4]),
        .f     (in_s[5]),
        .terms (terms_next),
        .y_nxt (y_next)
    );

    logic                 y_reg;
    logic [NUM_TERMS-1:0] terms_reg;
    logic                 y_chg_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 chg_next;
    logic [CNT_W-1:0]     cnt_next;

    // Change detect against the currently held output; counter holds at max
    always_comb begin
        chg_next = (y_next != y_reg);
        cnt_next = cnt_reg;
        if (chg_next && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Output registers; reset wins over any sample presented on this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg     <= Y_RST;
            terms_reg <= '0;
            y_chg_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            y_reg     <= y_next;
            terms_reg <= terms_next;
            y_chg_reg <= chg_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign y       = y_reg;
    assign terms   = terms_reg;
    assign y_chg   = y_chg_reg;
    assign chg_cnt = cnt_reg;

endmodule

// File: tb/tb_first_circuit.sv
// Scoreboard bench for first_circuit: a default-width instance and a
// 2-bit-counter instance share the same inputs.
module tb_first_circuit;

`ifdef FIRST_CIRCUIT_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 0, b = 0, c = 0, d = 0, e = 0, f = 0;
    logic       y8, y2, chg8, chg2;
    logic [2:0] terms8, terms2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         due;
        logic [2:0] terms;
        logic       y;
        logic       chg;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    exp_t q[$];

    // Reference state
    logic       m_y;
    logic [7:0] m_cnt8;
    logic [1:0] m_cnt2;

    always #5 clk = ~clk;

    first_circuit dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y(y8), .terms(terms8), .y_chg(chg8), .chg_cnt(cnt8)
    );

    first_circuit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y(y2), .terms(terms2), .y_chg(chg2), .chg_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all(input exp_t x);
        check("y", {31'd0, y8}, {31'd0, x.y});
        check("terms", {29'd0, terms8}, {29'd0, x.terms});
        check("y_chg", {31'd0, chg8}, {31'd0, x.chg});
        check("chg_cnt", {24'd0, cnt8}, {24'd0, x.cnt8});
        check("sat_y", {31'd0, y2}, {31'd0, x.y});
        check("sat_y_chg", {31'd0, chg2}, {31'd0, x.chg});
        check("sat_chg_cnt", {30'd0, cnt2}, {30'd0, x.cnt2});
        $display("cyc=%0d y=%0b terms=%03b y_chg=%0b cnt=%0d cnt_sat=%0d",
                 cyc, y8, terms8, chg8, cnt8, cnt2);
    endtask

    // Drive one sample, push its expected result, advance one edge and
    // compare whatever has become due
    task automatic step(input logic [5:0] v);
        exp_t x;
        {f, e, d, c, b, a} = v;
        x.terms = {v[4] & v[5], v[2] & v[3], v[0] & v[1]};
        x.y     = (x.terms == 3'b000);
        x.chg   = (x.y != m_y);
        if (x.chg) begin
            if (m_cnt8 != 8'hff) m_cnt8 = m_cnt8 + 1;
            if (m_cnt2 != 2'h3)  m_cnt2 = m_cnt2 + 1;
        end
        m_y    = x.y;
        x.cnt8 = m_cnt8;
        x.cnt2 = m_cnt2;
        x.due  = cyc + LAT;
        q.push_back(x);
        tick();
        while (q.size() > 0 && q[0].due == cyc) check_all(q.pop_front());
    endtask

    task automatic flush();
        for (int i = 0; i < LAT && q.size() > 0; i++) begin
            tick();
            while (q.size() > 0 && q[0].due == cyc) check_all(q.pop_front());
        end
        check("queue_empty", q.size(), 0);
    endtask

    task automatic do_reset(input int n);
        exp_t x;
        rst = 1'b1;
        q.delete();
        m_y = 1'b1; m_cnt8 = '0; m_cnt2 = '0;
        x.y = 1'b1; x.terms = '0; x.chg = 1'b0; x.cnt8 = '0; x.cnt2 = '0; x.due = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            check_all(x);
        end
        rst = 1'b0;
    endtask

    // Input vectors are packed {f,e,d,c,b,a}
    initial begin
        m_y = 1'b1; m_cnt8 = '0; m_cnt2 = '0;
        do_reset(2);

        step(6'b001001);   // a=1,d=1: no term, y=1
        step(6'b001100);   // c&d: y=0, pulse, cnt 1
        step(6'b001001);   // back to y=1, pulse, cnt 2
        step(6'b101001);   // f=1,e=0: y stays 1
        step(6'b101001);   // steady: y_chg drops

        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 6'b000011 : 6'b000001);
        step(6'b110000);   // e&f only
        step(6'b111111);   // all terms
        step(6'b000000);   // all zero
        step(6'b000011);   // a&b: y=0 before mid-operation reset
        flush();

        check("pre_reset_y", {31'd0, y8}, 32'd0);
        step(6'b000011);
        step(6'b001100);
        do_reset(1);       // discard in-flight samples

        step(6'b001001);
        step(6'b001100);
        step(6'b001001);
        step(6'b101001);

        for (int i = 0; i < 40; i++) step(6'($urandom_range(0, 63)));
        for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 6'b110000 : 6'b000000);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
